neptune_pulse_window_counter: RTL and testbench
===============================================

// Module: neptune_pulse_window_counter
// PURPOSE
//   Front end of the Neptune tuner. Conditions the raw input_pulse pin and counts its
//   rising edges over a fixed gate window, whose length in cycles is chosen by clk_config.
//   Delivers one edge count per window, with a valid strobe, to the downstream note
//   classifier / proximity stage that drives the segments and prox_select.
// PARAMETERS
//   SYNC_STAGES  2     flops in the input synchroniser chain (>=2)
//   FILTER_LEN   3     consecutive equal samples needed to change the filtered level (>=1)
//   COUNT_W      8     width of the edge counter and of count_out
//   WIN_W        16    width of the gate-window down-counter
//   WIN0..WIN3   1000,2000,4000,3277  gate length in clk cycles for clk_config 0..3
// PORTS
//   clk           in   1        system clock
//   rst           in   1        asynchronous, active-low reset
//   clk_config    in   2        selects the gate length WIN[clk_config]
//   input_pulse   in   1        raw asynchronous signal to be measured
//   pulse_level   out  1        synchronised, glitch-filtered input level
//   edge_strobe   out  1        1-cycle pulse per filtered rising edge
//   count_out     out  COUNT_W  edge count of the last completed window
//   count_valid   out  1        1-cycle strobe: count_out updated this cycle
//   overflow      out  1        last completed window saturated the counter
// BEHAVIOUR
//   Reset: all flops, and all outputs, are 0. The FSM enters SETTLE and loads the window
//     counter with WIN[clk_config]-1.
//   Conditioning: an SYNC_STAGES-deep flop chain feeds the filter. pulse_level toggles only
//     after FILTER_LEN consecutive synced samples differ from it. A new level that lasts
//     fewer than FILTER_LEN cycles is discarded.
//   edge_strobe: asserts in the same cycle that pulse_level rises 0->1. With no glitch,
//     that is SYNC_STAGES+FILTER_LEN clocks after the first clk edge that samples input high.
//   cfg_q: clk_config is registered each cycle into cfg_q. WIN[cfg_q] sets the reload value.
//   Window counter: counts down to 0 each cycle. The cycle where it is 0 is the terminal
//     cycle. On that cycle it reloads WIN[cfg_q]-1, so the window period is WIN[cfg_q]
//     cycles exactly.
//   Edge counter: increments on edge_strobe and saturates at 2^COUNT_W-1. The sat flag is
//     set when an increment is attempted at the max value.
//   FSM states:
//     SETTLE : first window after reset or after a config change. Its result is discarded.
//              On the terminal cycle: clear the edge counter and sat, go to MEASURE.
//              No count_valid.
//     MEASURE: on the terminal cycle: count_out <= edge count, including any edge_strobe
//              in that same cycle (saturating); overflow <= sat; count_valid=1 for one
//              cycle. The edge counter clears to 0. Stay in MEASURE.
//   Config change: when clk_config != cfg_q, on the next clock:
//     - the window counter reloads WIN[new]-1;
//     - the edge counter and sat clear;
//     - the FSM goes to SETTLE; no count_valid is issued for the aborted window;
//     - count_out and overflow keep their last values.
//   Mid-window reset: everything returns to reset values immediately (async). Partial
//     counts are lost.
//   count_out/overflow: change only when count_valid=1; they hold between strobes.
// STRUCTURE
//   neptune_pkg: COUNT_W, WIN_W, WIN0..WIN3 defaults, FSM state enum (SETTLE, MEASURE),
//     and the function win_len(cfg) that returns WIN[cfg].
//   Sub-module neptune_pulse_conditioner: synchroniser, glitch filter and rising-edge
//     detect. Outputs pulse_level and edge_strobe.
//   Top level: cfg register, window counter, edge counter, FSM and output registers.
// TESTING
//   Reset, cfg=0, square wave period 40 cycles: no count_valid in the first 1000-cycle
//     window; then count_valid every 1000 cycles with count_out=25 and overflow=0.
//   Glitches: 2-cycle high pulses on input_pulse every 50 cycles -> pulse_level stays 0,
//     no edge_strobe, count_out=0. A 3-cycle pulse -> edge_strobe exactly 5 cycles after
//     the rise.
//   cfg=2, period 8 cycles (500 edges/window) -> count_out=255, overflow=1. Then period
//     40 cycles -> next window gives count_out=100, overflow=0.
//   Edge on terminal cycle: edge_strobe aligned to the terminal cycle is counted in the
//     closing window. The next window starts from 0.
//   Switch clk_config 0->1 mid-window -> no strobe for the aborted window; one SETTLE
//     window of 2000 cycles; then valid every 2000 cycles with count_out=50 at period 40.
//   Assert rst low for 1 cycle mid-window -> all outputs 0 immediately; the first valid
//     comes 2 windows after release.

Source files
------------

// File: rtl/neptune_pkg.sv
// Shared constants, FSM state type and gate-length lookup for the Neptune tuner front end.
package neptune_pkg;

  localparam int unsigned COUNT_W = 8;
  localparam int unsigned WIN_W   = 16;

  localparam int unsigned WIN0 = 1000;
  localparam int unsigned WIN1 = 2000;
  localparam int unsigned WIN2 = 4000;
  localparam int unsigned WIN3 = 3277;

  typedef enum logic {
    SETTLE  = 1'b0,
    MEASURE = 1'b1
  } state_t;

  function automatic int unsigned win_len(input logic [1:0] cfg);
    case (cfg)
      2'd0:    return WIN0;
      2'd1:    return WIN1;
      2'd2:    return WIN2;
      default: return WIN3;
    endcase
  endfunction

endpackage

// File: rtl/neptune_pulse_window_counter_conditioner.sv
// Synchroniser, glitch filter and rising-edge detect for the raw input pulse.
module neptune_pulse_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic input_pulse,
  output logic pulse_level,
  output logic edge_strobe
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], input_pulse};
    end
  end

  // cnt holds how many consecutive synced samples have disagreed with the
  // current level; the level flips one cycle after the FILTER_LEN-th one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      pulse_level <= 1'b0;
      edge_strobe <= 1'b0;
    end else begin
      edge_strobe <= 1'b0;
      if (cnt == FULL) begin
        pulse_level <= ~pulse_level;
        edge_strobe <= ~pulse_level;
        cnt         <= (synced == pulse_level) ? CNT_W'(1) : '0;
      end else if (synced != pulse_level) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/neptune_pulse_window_counter.sv
// Neptune tuner front end: counts filtered rising edges of input_pulse per gate window.
module neptune_pulse_window_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned COUNT_W     = neptune_pkg::COUNT_W,
  parameter int unsigned WIN_W       = neptune_pkg::WIN_W,
  parameter int unsigned WIN0        = neptune_pkg::win_len(2'd0),
  parameter int unsigned WIN1        = neptune_pkg::win_len(2'd1),
  parameter int unsigned WIN2        = neptune_pkg::win_len(2'd2),
  parameter int unsigned WIN3        = neptune_pkg::win_len(2'd3)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         clk_config,
  input  logic               input_pulse,
  output logic               pulse_level,
  output logic               edge_strobe,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  output logic               overflow
);

  import neptune_pkg::*;

  logic [1:0]         cfg_q;
  logic [WIN_W-1:0]   win_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic               sat;
  state_t             state;

  logic               cfg_change;
  logic               terminal;
  logic               cnt_max;
  logic [COUNT_W-1:0] edge_next;
  logic               sat_next;

  function automatic logic [WIN_W-1:0] reload_val(input logic [1:0] cfg);
    case (cfg)
      2'd0:    return WIN_W'(WIN0 - 1);
      2'd1:    return WIN_W'(WIN1 - 1);
      2'd2:    return WIN_W'(WIN2 - 1);
      default: return WIN_W'(WIN3 - 1);
    endcase
  endfunction

  neptune_pulse_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_conditioner (
    .clk         (clk),
    .rst         (rst),
    .input_pulse (input_pulse),
    .pulse_level (pulse_level),
    .edge_strobe (edge_strobe)
  );

  // edge_next/sat_next include this cycle's strobe, so an edge on the terminal
  // cycle lands in the window that is closing.
  always_comb begin
    cfg_change = (clk_config != cfg_q);
    terminal   = (win_cnt == '0);
    cnt_max    = (edge_cnt == '1);
    edge_next  = edge_cnt;
    sat_next   = sat;
    if (edge_strobe) begin
      if (cnt_max) begin
        sat_next = 1'b1;
      end else begin
        edge_next = edge_cnt + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q       <= '0;
      win_cnt     <= reload_val(2'd0);
      edge_cnt    <= '0;
      sat         <= 1'b0;
      state       <= SETTLE;
      count_out   <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      cfg_q       <= clk_config;
      count_valid <= 1'b0;
      if (cfg_change) begin
        win_cnt  <= reload_val(clk_config);
        edge_cnt <= '0;
        sat      <= 1'b0;
        state    <= SETTLE;
      end else if (terminal) begin
        win_cnt  <= reload_val(cfg_q);
        edge_cnt <= '0;
        sat      <= 1'b0;
        state    <= MEASURE;
        if (state == MEASURE) begin
          count_out   <= edge_next;
          overflow    <= sat_next;
          count_valid <= 1'b1;
        end
      end else begin
        win_cnt  <= win_cnt - WIN_W'(1);
        edge_cnt <= edge_next;
        sat      <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_neptune_pulse_window_counter.sv
// Directed self-checking bench for neptune_pulse_window_counter.
module tb_neptune_pulse_window_counter;

  logic       clk;
  logic       rst;
  logic [1:0] clk_config;
  logic       input_pulse;
  logic       pulse_level;
  logic       edge_strobe;
  logic [7:0] count_out;
  logic       count_valid;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;

  // input generator: 0 low, 1 square of period per, 2 2-cycle glitch every 50, 3 manual
  int   mode    = 0;
  int   per     = 40;
  int   ph      = 0;
  logic man_lvl = 1'b0;

  neptune_pulse_window_counter dut (
    .clk         (clk),
    .rst         (rst),
    .clk_config  (clk_config),
    .input_pulse (input_pulse),
    .pulse_level (pulse_level),
    .edge_strobe (edge_strobe),
    .count_out   (count_out),
    .count_valid (count_valid),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    input_pulse = 1'b0;
    forever begin
      @(negedge clk);
      ph++;
      case (mode)
        1:       input_pulse = ((ph % per) < (per / 2));
        2:       input_pulse = ((ph % 50) < 2);
        3:       input_pulse = man_lvl;
        default: input_pulse = 1'b0;
      endcase
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int n, output int strobes, output bit lvl);
    n       = limit + 1;
    strobes = 0;
    lvl     = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (count_valid) begin
        n = i;
        break;
      end
      if (edge_strobe) strobes++;
      if (pulse_level) lvl = 1'b1;
    end
  endtask

  int n;
  int s;
  bit l;
  int k;

  initial begin
    rst        = 1'b0;
    clk_config = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count_out", count_out, 0);
    chk("rst_count_valid", count_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_pulse_level", pulse_level, 0);
    chk("rst_edge_strobe", edge_strobe, 0);

    // cfg 0, period 40: settle window, then 25 edges per 1000 cycles
    mode = 1;
    per  = 40;
    @(negedge clk);
    rst = 1'b1;
    wait_valid(2500, n, s, l);
    chk("first_valid_latency", n, 2000);
    chk("p40_count", count_out, 25);
    chk("p40_overflow", overflow, 0);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", count_valid, 0);
    chk("count_hold", count_out, 25);
    wait_valid(1500, n, s, l);
    chk("p40_period", n, 999);
    chk("p40_count2", count_out, 25);

    // short glitches must be filtered out entirely
    mode = 2;
    wait_valid(1500, n, s, l);
    wait_valid(1500, n, s, l);
    chk("glitch_period", n, 1000);
    chk("glitch_strobes", s, 0);
    chk("glitch_level", l, 0);
    chk("glitch_count", count_out, 0);
    chk("glitch_overflow", overflow, 0);

    // 3-cycle pulse survives: strobe 5 clocks after the first sampling edge
    mode    = 3;
    man_lvl = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    man_lvl = 1'b1;
    k = 0;
    s = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) man_lvl = 1'b0;
      if (edge_strobe) begin
        s++;
        if (k == 0) begin
          k = i;
          chk("pulse3_level", pulse_level, 1);
        end
      end
    end
    chk("pulse3_delay", k - 1, 5);
    chk("pulse3_strobes", s, 1);
    chk("pulse3_level_back", pulse_level, 0);

    // cfg 2, period 8: 500 edges saturate the counter
    mode       = 1;
    per        = 8;
    clk_config = 2'd2;
    wait_valid(9000, n, s, l);
    chk("cfg2_latency", n, 8001);
    chk("sat_count", count_out, 255);
    chk("sat_overflow", overflow, 1);
    per = 40;
    wait_valid(4500, n, s, l);
    chk("cfg2_period", n, 4000);
    wait_valid(4500, n, s, l);
    chk("p40_cfg2_count", count_out, 100);
    chk("p40_cfg2_overflow", overflow, 0);

    // edge strobe on the terminal cycle counts in the closing window
    mode    = 3;
    man_lvl = 1'b0;
    wait_valid(4500, n, s, l);
    chk("quiet_period", n, 4000);
    repeat (4000 - 7) @(posedge clk);
    #1;
    man_lvl = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    man_lvl = 1'b0;
    wait_valid(100, n, s, l);
    chk("term_edge_latency", n, 4);
    chk("term_edge_count", count_out, 1);
    chk("term_edge_overflow", overflow, 0);
    wait_valid(4500, n, s, l);
    chk("after_term_period", n, 4000);
    chk("after_term_count", count_out, 0);

    // config change mid-window aborts it and re-settles
    mode       = 1;
    per        = 40;
    clk_config = 2'd0;
    wait_valid(3000, n, s, l);
    chk("cfg0_latency", n, 2001);
    chk("cfg0_count", count_out, 25);
    repeat (500) @(posedge clk);
    #1;
    clk_config = 2'd1;
    @(posedge clk);
    #1;
    chk("cfgchg_hold_count", count_out, 25);
    chk("cfgchg_no_valid", count_valid, 0);
    wait_valid(6000, n, s, l);
    chk("cfg1_latency", n, 4000);
    chk("cfg1_count", count_out, 50);
    wait_valid(2500, n, s, l);
    chk("cfg1_period", n, 2000);
    chk("cfg1_count2", count_out, 50);

    // mid-window reset clears everything at once
    repeat (300) @(posedge clk);
    #1;
    rst        = 1'b0;
    clk_config = 2'd0;
    #1;
    chk("mid_rst_count_out", count_out, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_valid", count_valid, 0);
    chk("mid_rst_level", pulse_level, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_valid(3000, n, s, l);
    chk("post_rst_latency", n, 2000);
    chk("post_rst_count", count_out, 25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
